// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks a synchronous 128x8 program ROM and issues 1/2-byte instructions.
// Build option FETCH_ILLEGAL_TRAP_EN: undefined opcodes set illegal_op and halt until reset.
module instr_fetch_unit (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] rom_address,
    input  logic [7:0] rom_data,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_operand,
    output logic       instr_has_operand,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    output logic [7:0] pc,
    output logic       addr_error,
    output logic       illegal_op
);

    typedef enum logic [2:0] {
        StFetchOp,
        StLatchOp,
        StFetchArg,
        StLatchArg,
        StIssue,
        StHalt
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] fptr_q, fptr_d;
    logic [6:0] pc_q, pc_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] operand_q, operand_d;
    logic       has_q, has_d;
    logic       valid_q, valid_d;
    logic       aerr_q, aerr_d;
    logic       illegal_q, illegal_d;

    logic [6:0] fptr_inc;
    logic [6:0] next_ptr;
    logic       two_byte;

    assign fptr_inc = fptr_q + 7'd1;
    assign next_ptr = branch_taken ? branch_target[6:0] : fptr_q;
    assign two_byte = rom_data inside {8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h98,
                                       [8'h20:8'h28]};

`ifdef FETCH_ILLEGAL_TRAP_EN
    logic one_byte;
    assign one_byte = rom_data inside {[8'h42:8'h46], 8'h48, [8'h4A:8'h4F]};
`endif

    always_comb begin
        state_d   = state_q;
        fptr_d    = fptr_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        has_d     = has_q;
        valid_d   = valid_q;
        aerr_d    = aerr_q;
        illegal_d = illegal_q;

        unique case (state_q)
            StFetchOp: begin
                state_d = StLatchOp;
            end
            StLatchOp: begin
                opcode_d  = rom_data;
                operand_d = 8'h00;
                if (two_byte) begin
                    fptr_d  = fptr_inc;
                    has_d   = 1'b1;
                    state_d = StFetchArg;
                end else begin
`ifdef FETCH_ILLEGAL_TRAP_EN
                    // Pointer left on the offending opcode so the halt address is visible.
                    if (!one_byte) begin
                        illegal_d = 1'b1;
                        has_d     = 1'b0;
                        state_d   = StHalt;
                    end else begin
                        fptr_d  = fptr_inc;
                        has_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = StIssue;
                    end
`else
                    fptr_d  = fptr_inc;
                    has_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = StIssue;
`endif
                end
            end
            StFetchArg: begin
                state_d = StLatchArg;
            end
            StLatchArg: begin
                operand_d = rom_data;
                fptr_d    = fptr_inc;
                valid_d   = 1'b1;
                state_d   = StIssue;
            end
            StIssue: begin
                // fptr_q already points past the issued instruction here.
                if (valid_q && instr_ready) begin
                    fptr_d  = next_ptr;
                    pc_d    = next_ptr;
                    valid_d = 1'b0;
                    state_d = StFetchOp;
                    if (branch_taken && branch_target[7]) begin
                        aerr_d = 1'b1;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
                valid_d = 1'b0;
            end
            default: begin
                state_d = StFetchOp;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetchOp;
            fptr_q    <= 7'd0;
            pc_q      <= 7'd0;
            opcode_q  <= 8'h00;
            operand_q <= 8'h00;
            has_q     <= 1'b0;
            valid_q   <= 1'b0;
            aerr_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fptr_q    <= fptr_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            has_q     <= has_d;
            valid_q   <= valid_d;
            aerr_q    <= aerr_d;
            illegal_q <= illegal_d;
        end
    end

    assign rom_address       = {1'b0, fptr_q};
    assign pc                = {1'b0, pc_q};
    assign instr_opcode      = opcode_q;
    assign instr_operand     = operand_q;
    assign instr_has_operand = has_q;
    assign instr_valid       = valid_q;
    assign addr_error        = aerr_q;
    assign illegal_op        = illegal_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a ROM model plus an instruction-stream reference model.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rom_address, rom_data;
    logic [7:0] instr_opcode, instr_operand, pc, branch_target;
    logic       instr_has_operand, instr_valid, instr_ready, branch_taken;
    logic       addr_error, illegal_op;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .rom_address      (rom_address),
        .rom_data         (rom_data),
        .instr_opcode     (instr_opcode),
        .instr_operand    (instr_operand),
        .instr_has_operand(instr_has_operand),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .pc               (pc),
        .addr_error       (addr_error),
        .illegal_op       (illegal_op)
    );

    // Synchronous program ROM
    logic [7:0] rom [128];
    always @(posedge clk) rom_data <= rom[rom_address[6:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
    endfunction

    typedef struct {
        logic [7:0] op;
        logic [7:0] arg;
        logic       has;
        logic [7:0] pc;
        int         exp_cyc;
        logic       aerr;
    } exp_t;

    exp_t       sbq[$];
    exp_t       cur;
    logic [8:0] br_plan[$];
    logic [7:0] legal[$];

    // Reference model state: where the next instruction starts and what was seen so far.
    int m_ptr = 0;
    int m_len = 1;
    bit m_aerr = 0;

    int  hs_count = 0;
    int  dcnt = 0;
    int  ready_mode = 0;  // 0 always ready, 1 random, 2 hold off six cycles
    bit  rand_br = 0;
    bit  run_en = 0;
    bit  chk_addr_pend = 0;
    logic [7:0] chk_addr_val;

    function automatic bit two_byte_op(logic [7:0] op);
        return (op inside {8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h98})
               || (op >= 8'h20 && op <= 8'h28);
    endfunction

    function automatic bit defined_op(logic [7:0] op);
        return two_byte_op(op) || (op >= 8'h42 && op <= 8'h46) || op == 8'h48
               || (op >= 8'h4A && op <= 8'h4F);
    endfunction

    function automatic void push_expect(int base);
        exp_t e;
        e.op      = rom[m_ptr];
        e.has     = two_byte_op(e.op);
        e.arg     = e.has ? rom[(m_ptr + 1) % 128] : 8'h00;
        e.pc      = 8'(m_ptr);
        e.exp_cyc = base + (e.has ? 4 : 2);
        e.aerr    = m_aerr;
        m_len     = e.has ? 2 : 1;
        sbq.push_back(e);
    endfunction

    function automatic void model_handshake(bit take, logic [7:0] tgt);
        if (take) begin
            m_ptr = int'(tgt[6:0]);
            if (tgt[7]) m_aerr = 1;
        end else begin
            m_ptr = (m_ptr + m_len) % 128;
        end
        push_expect(cyc + 1);
    endfunction

    // Driver: decides ready/branch just after each posedge; branch inputs are noise
    // except on a handshake cycle.
    initial begin : driver
        logic       rdy, bt;
        logic [7:0] tg;
        logic [8:0] bp;
        forever begin
            @(posedge clk);
            #1;
            if (chk_addr_pend) begin
                check("fetch_addr_after_handshake", rom_address, chk_addr_val);
                chk_addr_pend = 0;
            end
            bt  = 1'($urandom_range(0, 1));
            tg  = 8'($urandom);
            rdy = 1'b0;
            if (run_en && instr_valid) begin
                dcnt++;
                case (ready_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 2) != 0);
                    default: rdy = (dcnt >= 7);
                endcase
                if (rdy) begin
                    if (br_plan.size() > 0) begin
                        bp = br_plan.pop_front();
                        bt = bp[8];
                        tg = bp[7:0];
                    end else if (rand_br) begin
                        bt = ($urandom_range(0, 3) == 0);
                    end else begin
                        bt = 1'b0;
                    end
                    model_handshake(bt, tg);
                    chk_addr_val  = 8'(m_ptr);
                    chk_addr_pend = 1;
                    hs_count++;
                    dcnt = 0;
                end
            end else if (run_en && ready_mode == 1) begin
                rdy = 1'($urandom_range(0, 1));
            end
            instr_ready   = rdy;
            branch_taken  = bt;
            branch_target = tg;
        end
    end

    // Monitor: pops one expectation per issued instruction and watches it stay stable.
    initial begin : monitor
        bit active = 0;
        int mcnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                active = 0;
                continue;
            end
            if (instr_valid) begin
                if (!active) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_issue", 32'(instr_opcode), 32'hFFFF_FFFF);
                        cur.op  = instr_opcode;
                        cur.arg = instr_operand;
                        cur.has = instr_has_operand;
                        cur.pc  = pc;
                    end else begin
                        cur = sbq.pop_front();
                        check("opcode", instr_opcode, cur.op);
                        check("operand", instr_operand, cur.arg);
                        check("has_operand", instr_has_operand, cur.has);
                        check("pc", pc, cur.pc);
                        check("issue_latency", cyc, cur.exp_cyc);
                        check("addr_error", addr_error, cur.aerr);
                    end
                    active = 1;
                    mcnt = 0;
                end else begin
                    check("issue_stable", {instr_opcode, instr_operand, pc, 7'd0, instr_has_operand},
                          {cur.op, cur.arg, cur.pc, 7'd0, cur.has});
                end
                mcnt++;
                if (instr_ready) begin
                    if (ready_mode == 2) check("hold_valid_cycles", mcnt, 7);
                    active = 0;
                end
            end
        end
    end

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 128; i++) rom[i] = v;
    endtask

    task automatic start_phase();
        @(posedge clk);
        #3;
        reset = 1'b0;
        run_en = 0;
        chk_addr_pend = 0;
        repeat (2) @(posedge clk);
        #3;
        sbq.delete();
        br_plan.delete();
        hs_count = 0;
        dcnt = 0;
    endtask

    task automatic release_reset(input bit push, input bit run);
        @(negedge clk);
        reset = 1'b1;
        m_ptr = 0;
        m_aerr = 0;
        if (push) push_expect(cyc);
        run_en = run;
    endtask

    task automatic wait_hs(input int n, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #2;
            if (hs_count >= n) break;
        end
        check("handshakes_reached", 32'(hs_count >= n), 1);
    endtask

    initial begin : main
        reset = 1'b0;
        instr_ready = 1'b0;
        branch_taken = 1'b0;
        branch_target = 8'h00;
        for (int v = 0; v < 256; v++) if (defined_op(8'(v))) legal.push_back(8'(v));
        fill_rom(8'h42);
        repeat (3) @(posedge clk);
        #3;
        check("rst_valid", instr_valid, 0);
        check("rst_pc", pc, 0);
        check("rst_rom_address", rom_address, 0);
        check("rst_opcode", instr_opcode, 0);
        check("rst_operand", instr_operand, 0);
        check("rst_has_operand", instr_has_operand, 0);
        check("rst_addr_error", addr_error, 0);
        check("rst_illegal_op", illegal_op, 0);

        // Two-byte then one-byte sequence, always ready
        start_phase();
        fill_rom(8'h42);
        rom[0] = 8'h86;
        rom[1] = 8'h07;
        rom[2] = 8'h42;
        ready_mode = 0;
        rand_br = 0;
        release_reset(1, 1);
        wait_hs(3, 100);

        // Ready held low for six cycles in ISSUE
        start_phase();
        ready_mode = 2;
        release_reset(1, 1);
        wait_hs(3, 200);

        // Taken branch to 05
        start_phase();
        fill_rom(8'h42);
        rom[0] = 8'h20;
        rom[1] = 8'h05;
        ready_mode = 0;
        br_plan.push_back({1'b1, 8'h05});
        release_reset(1, 1);
        wait_hs(3, 100);

        // Two-byte opcode at 7F takes its operand from 00
        start_phase();
        fill_rom(8'h42);
        rom[1] = 8'h43;
        rom[127] = 8'h86;
        br_plan.push_back({1'b1, 8'h7F});
        release_reset(1, 1);
        wait_hs(3, 100);

        // Out-of-range target E0
        start_phase();
        fill_rom(8'h42);
        br_plan.push_back({1'b1, 8'hE0});
        release_reset(1, 1);
        wait_hs(3, 100);
        check("addr_error_sticky", addr_error, 1);

        // Randomised program, ready and branches
        start_phase();
        check("addr_error_cleared", addr_error, 0);
        for (int i = 0; i < 128; i++) rom[i] = legal[$urandom_range(0, legal.size() - 1)];
        ready_mode = 1;
        rand_br = 1;
        release_reset(1, 1);
        wait_hs(150, 4000);

        // Undefined opcode FF at address 0
        start_phase();
        fill_rom(8'h42);
        rom[0] = 8'hFF;
        ready_mode = 0;
        rand_br = 0;
`ifdef FETCH_ILLEGAL_TRAP_EN
        release_reset(0, 1);
        repeat (8) @(posedge clk);
        #2;
        check("trap_illegal_op", illegal_op, 1);
        check("trap_no_valid", instr_valid, 0);
        check("trap_rom_address", rom_address, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("trap_illegal_cleared", illegal_op, 0);
`else
        release_reset(1, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (instr_valid) break;
        end
        check("ff_reached_issue", instr_valid, 1);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        run_en = 0;
        chk_addr_pend = 0;
        #1;
        check("valid_drop_on_reset", instr_valid, 0);
        check("illegal_op_stays_low", illegal_op, 0);
        check("pc_after_reset", pc, 0);
        repeat (2) @(posedge clk);
        #3;
        sbq.delete();
        hs_count = 0;
        dcnt = 0;
        release_reset(1, 1);
        wait_hs(2, 50);
`endif

        @(posedge clk);
        #3;
        reset = 1'b0;
        run_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on posedge clk.
REQ-002 reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately.
REQ-003 rom_address  output  8  byte address driven to the synchronous 128x8 program ROM; bit 7 always 0.
REQ-004 rom_data  input  8  ROM data_out; holds ROM[rom_address] sampled at the previous posedge.
REQ-005 instr_opcode  output  8  opcode of the issued instruction.
REQ-006 instr_operand  output  8  operand byte; 8'h00 for one-byte instructions.
REQ-007 instr_has_operand  output  1  1 = two-byte instruction.
REQ-008 instr_valid  output  1  instruction presented to the control unit.
REQ-009 instr_ready  input  1  control unit accepts; handshake = instr_valid & instr_ready.
REQ-010 branch_taken  input  1  redirect request; sampled only on the handshake cycle.
REQ-011 branch_target  input  8  redirect ROM address.
REQ-012 pc  output  8  address of the opcode byte of the current instruction.
REQ-013 addr_error  output  1  sticky flag: a branch target >= 8'h80 was received.
REQ-014 illegal_op  output  1  sticky flag: an undefined opcode was fetched.

Function
REQ-015 States SHALL be FETCH_OP, LATCH_OP, FETCH_ARG, LATCH_ARG, ISSUE, HALT.
REQ-016 In FETCH_OP and FETCH_ARG, rom_address SHALL equal the fetch pointer; the next state is LATCH_OP or LATCH_ARG respectively.
REQ-017 In LATCH_OP, rom_data SHALL be captured as the opcode and the fetch pointer incremented.
- Two-byte opcodes {86,87,88,89,96,97,98,20..28}: next state FETCH_ARG.
- Defined one-byte opcodes {42..46,48,4A..4F}: next state ISSUE.
REQ-018 In LATCH_ARG, rom_data SHALL be captured as the operand, the fetch pointer incremented, and the next state SHALL be ISSUE.
REQ-019 Latency from entering FETCH_OP to instr_valid SHALL be 2 cycles for one-byte and 4 cycles for two-byte instructions.
REQ-020 In ISSUE, instr_valid=1 and opcode, operand, has_operand and pc SHALL hold stable until the handshake.
REQ-021 On the handshake, the fetch pointer SHALL become branch_taken ? branch_target[6:0] : the sequential pointer, and the next state SHALL be FETCH_OP.
REQ-022 The fetch pointer SHALL be 7 bits and wrap from 7'h7F to 7'h00 on increment, including mid-instruction (operand at 0x00).
REQ-023 A branch_target with bit 7 set SHALL set addr_error and load target[6:0].
REQ-024 pc SHALL update to the fetch pointer value on entry to FETCH_OP only.
REQ-025 branch_taken and branch_target SHALL be ignored outside the handshake cycle.
REQ-026 instr_valid SHALL be 0 in every state except ISSUE.

Reset
REQ-027 While reset=0, the block SHALL set state=FETCH_OP, fetch pointer=0, pc=0, and instr_opcode, instr_operand, instr_has_operand, instr_valid, addr_error and illegal_op all to 0.
REQ-028 Reset asserted mid-fetch or mid-ISSUE SHALL discard the in-flight instruction; after release, fetch SHALL restart at address 0 on the first clk edge.

Configuration
REQ-029 Macro FETCH_ILLEGAL_TRAP_EN controls undefined-opcode handling.
- Defined: an undefined opcode in LATCH_OP sets illegal_op, and the block enters HALT (instr_valid=0, rom_address frozen) until reset.
- Undefined: an undefined opcode is issued as a one-byte instruction, and illegal_op stays 0.

Verification
REQ-030 ROM[0]=86, ROM[1]=07, ROM[2]=42; instr_ready=1 -> first issue (86,07,has=1,pc=0) at cycle 5; then (42,00,has=0,pc=2) 3 cycles after the handshake.
REQ-031 Hold instr_ready=0 for 6 cycles while in ISSUE -> outputs stable and instr_valid=1 for all 6 cycles; a single handshake occurs.
REQ-032 Issue BRA 05 with branch_taken=1, branch_target=05 on the handshake -> next rom_address=05 and pc=05.
REQ-033 Two-byte opcode at 7F -> operand fetched from 00; next pc=01.
REQ-034 branch_target=8'hE0 -> addr_error=1 (sticky) and next fetch at 0x60.
REQ-035 Opcode 8'hFF fetched -> with FETCH_ILLEGAL_TRAP_EN: illegal_op=1 and HALT; without it: issued (FF,00,has=0). Then reset=0 mid-ISSUE -> instr_valid=0 immediately, restart at 0.
